// File: rtl/regression_sequencer.sv
// Two-pass sequencer for the linear-regression datapath: averages pass, SS pass,
// divider handoff, coefficient latch and completion report to the error checker.
module regression_sequencer #(
    parameter int N_SAMPLES = 150,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              div_done_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              clr_acc_o,
    output logic              acc_en_o,
    output logic              load_avg_o,
    output logic              clr_ss_o,
    output logic              ss_en_o,
    output logic              div_start_o,
    output logic              load_coef_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_en_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

    typedef enum logic [3:0] {
        IDLE, CLR_ACC, RD_SUM, DRAIN_SUM, LOAD_AVG, CLR_SS,
        RD_SS, DRAIN_SS, DIV_GO, DIV_WAIT, LOAD_COEF, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_rd_d;
    logic              mem_rd_q, clr_acc_q, acc_en_q, load_avg_q, clr_ss_q, ss_en_q;
    logic              div_start_q, load_coef_q, busy_q, done_q, err_en_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_i && !abort_i) state_d = CLR_ACC;
            CLR_ACC:   state_d = RD_SUM;
            RD_SUM:    if (addr_q == LAST_ADDR) state_d = DRAIN_SUM;
            DRAIN_SUM: state_d = LOAD_AVG;
            LOAD_AVG:  state_d = CLR_SS;
            CLR_SS:    state_d = RD_SS;
            RD_SS:     if (addr_q == LAST_ADDR) state_d = DRAIN_SS;
            DRAIN_SS:  state_d = DIV_GO;
            DIV_GO:    state_d = DIV_WAIT;
            DIV_WAIT:  if (div_done_i) state_d = LOAD_COEF;
            LOAD_COEF: state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (state_q != IDLE && abort_i) state_d = IDLE;

        // Address restarts at 0 on entry to each read pass and stays 0 outside them.
        in_rd_d = (state_d == RD_SUM) || (state_d == RD_SS);
        addr_d  = '0;
        if (in_rd_d && state_d == state_q) addr_d = addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mem_rd_q    <= 1'b0;
            clr_acc_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            load_avg_q  <= 1'b0;
            clr_ss_q    <= 1'b0;
            ss_en_q     <= 1'b0;
            div_start_q <= 1'b0;
            load_coef_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_rd_q    <= in_rd_d;
            clr_acc_q   <= (state_d == CLR_ACC);
            load_avg_q  <= (state_d == LOAD_AVG);
            clr_ss_q    <= (state_d == CLR_SS);
            div_start_q <= (state_d == DIV_GO);
            load_coef_q <= (state_d == LOAD_COEF);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            // Read data lands one cycle after the read; an abort drops the pending beat.
            acc_en_q    <= (state_q == RD_SUM) && (state_d != IDLE);
            ss_en_q     <= (state_q == RD_SS) && (state_d != IDLE);
            if (state_d == DONE)
                err_en_q <= 1'b1;
            else if (state_d == CLR_ACC || (state_q != IDLE && abort_i))
                err_en_q <= 1'b0;
        end
    end

    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = addr_q;
    assign clr_acc_o   = clr_acc_q;
    assign acc_en_o    = acc_en_q;
    assign load_avg_o  = load_avg_q;
    assign clr_ss_o    = clr_ss_q;
    assign ss_en_o     = ss_en_q;
    assign div_start_o = div_start_q;
    assign load_coef_o = load_coef_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_en_o    = err_en_q;

endmodule

// File: tb/tb_regression_sequencer.sv
// Bench for regression_sequencer: two instances (N=4, N=1) checked cycle by cycle
// against a timeline model derived from the run's start cycle, divider wait and abort.
module tb_regression_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_s [2];
    logic       abort_s [2];
    logic       div_done_s [2];
    logic       mem_rd [2];
    logic [7:0] mem_addr [2];
    logic       clr_acc [2];
    logic       acc_en [2];
    logic       load_avg [2];
    logic       clr_ss [2];
    logic       ss_en [2];
    logic       div_start [2];
    logic       load_coef [2];
    logic       busy [2];
    logic       done [2];
    logic       err_en [2];

    int  n_checks;
    int  n_errors;
    logic err_st [2];

    regression_sequencer #(.N_SAMPLES(4), .ADDR_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .start_i(start_s[0]), .abort_i(abort_s[0]), .div_done_i(div_done_s[0]),
        .mem_rd_o(mem_rd[0]), .mem_addr_o(mem_addr[0]), .clr_acc_o(clr_acc[0]),
        .acc_en_o(acc_en[0]), .load_avg_o(load_avg[0]), .clr_ss_o(clr_ss[0]),
        .ss_en_o(ss_en[0]), .div_start_o(div_start[0]), .load_coef_o(load_coef[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_en_o(err_en[0])
    );

    regression_sequencer #(.N_SAMPLES(1), .ADDR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .start_i(start_s[1]), .abort_i(abort_s[1]), .div_done_i(div_done_s[1]),
        .mem_rd_o(mem_rd[1]), .mem_addr_o(mem_addr[1]), .clr_acc_o(clr_acc[1]),
        .acc_en_o(acc_en[1]), .load_avg_o(load_avg[1]), .clr_ss_o(clr_ss[1]),
        .ss_en_o(ss_en[1]), .div_start_o(div_start[1]), .load_coef_o(load_coef[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_en_o(err_en[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {mem_rd, mem_addr, clr_acc, acc_en, load_avg, clr_ss, ss_en, div_start, load_coef, busy, done, err_en}
    function automatic logic [18:0] observed(input int u);
        return {mem_rd[u], mem_addr[u], clr_acc[u], acc_en[u], load_avg[u], clr_ss[u],
                ss_en[u], div_start[u], load_coef[u], busy[u], done[u], err_en[u]};
    endfunction

    // Expected outputs in cycle k after the start edge (k=1 is CLR_ACC).
    function automatic logic [18:0] model(input int n, input int k, input int d, input int ab);
        logic       rd1, rd2;
        logic [7:0] a;
        if (ab > 0 && k > ab) return '0;
        rd1 = (k >= 2) && (k <= n + 1);
        rd2 = (k >= n + 5) && (k <= 2*n + 4);
        a   = rd1 ? 8'(k - 2) : (rd2 ? 8'(k - n - 5) : 8'd0);
        return {rd1 | rd2, a,
                k == 1,
                (k >= 3) && (k <= n + 2),
                k == n + 3,
                k == n + 4,
                (k >= n + 6) && (k <= 2*n + 5),
                k == 2*n + 6,
                k == 2*n + 8 + d,
                (k >= 1) && (k <= 2*n + 9 + d),
                k == 2*n + 9 + d,
                k >= 2*n + 9 + d};
    endfunction

    function automatic logic [18:0] idle_vec(input logic err);
        return {18'b0, err};
    endfunction

    // One run on unit u: d stalled DIV_WAIT cycles, abort in cycle ab (0 = none),
    // async reset in cycle rk (0 = none), noise = stray start/div_done pulses.
    task automatic run(input int u, input int d, input int ab, input int rk, input bit noise);
        int n, end_k, last_k, win_lo, win_hi;
        n      = (u == 0) ? 4 : 1;
        end_k  = 2*n + 9 + d;
        win_lo = 2*n + 7;
        win_hi = 2*n + 7 + d;
        last_k = (ab > 0) ? ab + 2 : ((rk > 0) ? rk : end_k + 1);
        @(negedge clk);
        check_eq($sformatf("idle_pre u%0d", u), 32'(observed(u)), 32'(idle_vec(err_st[u])));
        start_s[u]    = 1'b1;
        abort_s[u]    = 1'b0;
        div_done_s[u] = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            check_eq($sformatf("run u%0d d%0d ab%0d k%0d", u, d, ab, k),
                     32'(observed(u)), 32'(model(n, k, d, ab)));
            start_s[u] = (noise && k <= end_k && (ab == 0 || k < ab)) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (k >= win_lo && k <= win_hi)
                div_done_s[u] = (k == win_hi);
            else if (noise && k < win_lo)
                div_done_s[u] = ($urandom_range(0, 2) == 0);
            else
                div_done_s[u] = 1'b0;
            abort_s[u] = (k == ab);
            if (k == rk) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("async_reset u0", 32'(observed(0)), 32'd0);
                check_eq("async_reset u1", 32'(observed(1)), 32'd0);
                start_s[u]    = 1'b0;
                abort_s[u]    = 1'b0;
                div_done_s[u] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                err_st[0] = 1'b0;
                err_st[1] = 1'b0;
                return;
            end
        end
        start_s[u]    = 1'b0;
        abort_s[u]    = 1'b0;
        div_done_s[u] = 1'b0;
        err_st[u]     = (ab == 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2; i++) begin
            start_s[i]    = 1'b0;
            abort_s[i]    = 1'b0;
            div_done_s[i] = 1'b0;
            err_st[i]     = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_eq("reset u0", 32'(observed(0)), 32'd0);
        check_eq("reset u1", 32'(observed(1)), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, 0, 0, 0, 1'b0);
        run(0, 2, 0, 0, 1'b0);
        run(0, 0, 10, 0, 1'b0);
        run(0, 5, 0, 16, 1'b0);
        run(0, 0, 0, 0, 1'b0);
        run(0, 1, 0, 0, 1'b1);
        run(0, 0, 0, 0, 1'b0);
        run(1, 0, 0, 0, 1'b0);
        run(1, 3, 0, 0, 1'b1);

        @(negedge clk);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check_eq("start_with_abort_idle", 32'(observed(0)), 32'(idle_vec(err_st[0])));
        @(negedge clk);
        check_eq("start_with_abort_idle2", 32'(observed(0)), 32'(idle_vec(err_st[0])));

        for (int r = 0; r < 14; r++) begin
            int u, d, ab, n;
            u  = $urandom_range(0, 1);
            d  = $urandom_range(0, 6);
            n  = (u == 0) ? 4 : 1;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2*n + 9 + d) : 0;
            run(u, d, ab, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
